// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one FP multiplier among NREQ clients.
// Optional multiply watchdog is enabled by defining FP_ARB_TIMEOUT_EN.
module fp_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_in,
    input  logic [32*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 fp_start,
    output logic [31:0]          fp_a,
    output logic [31:0]          fp_b,
    input  logic [31:0]          fp_result,
    input  logic                 fp_done,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] sel;
    logic [IW-1:0] nxt_ptr;
    logic [IW:0]   idx;
    logic          found;
    logic          grant;
    logic          waiting;
    logic          timeout;
    logic          resp;
    logic [31:0]   held;
    logic [31:0]   a_arr [NREQ];
    logic [31:0]   b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = a_in[32*i +: 32];
        assign b_arr[i] = b_in[32*i +: 32];
    end

    // Scan from rr_ptr upward, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IW-1:0];
            end
        end
    end

    assign nxt_ptr = (sel == IW'(NREQ-1)) ? '0 : sel + IW'(1);
    assign grant   = (state == IDLE) && found;
    assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          held_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + CW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout = waiting && (wd_cnt == CW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            held_err <= 1'b0;
        end else if (state == WAIT_DONE && fp_done) begin
            held_err <= 1'b0;
        end else if (timeout) begin
            held_err <= 1'b1;
        end
    end

    assign rsp_err = resp && held_err;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (found) state_nx = ISSUE;
            end
            ISSUE: begin
                if (fp_done) state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout)      state_nx = RESP;
                else if (!fp_done) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (fp_done || timeout) state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Completion wins over a watchdog expiry landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fp_a   <= '0;
            fp_b   <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            held   <= '0;
        end else begin
            if (grant) begin
                fp_a   <= a_arr[sel];
                fp_b   <= b_arr[sel];
                owner  <= sel;
                rr_ptr <= nxt_ptr;
            end
            if (state == WAIT_DONE && fp_done) begin
                held <= fp_result;
            end else if (timeout) begin
                held <= 32'h7FC0_0000;
            end
        end
    end

    assign resp       = (state == RESP) && !rst;
    assign gnt        = (grant && !rst) ? (NREQ'(1) << sel) : '0;
    assign rsp_valid  = resp ? (NREQ'(1) << owner) : '0;
    assign rsp_result = resp ? held : '0;
    assign fp_start   = (state == ISSUE) && fp_done && !rst;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: scoreboard bench for fp_mult_arbiter with a behavioural
// multiplier (Idle->Init->load->norm->Idle); timeout case under FP_ARB_TIMEOUT_EN.
module tb_fp_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] FOUR  = 32'h4080_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   a_in;
    logic [32*NREQ-1:0]   b_in;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_result;
    logic                 rsp_err;
    logic                 fp_start;
    logic [31:0]          fp_a;
    logic [31:0]          fp_b;
    logic [31:0]          fp_result;
    logic                 fp_done;
    logic                 busy;

    always #5 clk = ~clk;

    fp_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .fp_start(fp_start), .fp_a(fp_a), .fp_b(fp_b),
        .fp_result(fp_result), .fp_done(fp_done), .busy(busy)
    );

    // Normal operands only, truncating; enough for exact directed vectors.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    typedef enum logic [1:0] {M_IDLE, M_INIT, M_LOAD, M_NORM} mst_t;
    mst_t        mst;
    logic        hang = 1'b0;
    logic [31:0] mres;

    always @(posedge clk) begin
        if (rst) begin
            mst  <= M_IDLE;
            mres <= '0;
        end else begin
            case (mst)
                M_IDLE: if (fp_start) mst <= M_INIT;
                M_INIT: mst <= M_LOAD;
                M_LOAD: if (!hang) mst <= M_NORM;
                M_NORM: begin
                    mst  <= M_IDLE;
                    mres <= fmul(fp_a, fp_b);
                end
                default: mst <= M_IDLE;
            endcase
        end
    end

    assign fp_done   = (mst == M_IDLE);
    assign fp_result = mres;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_tot   = 0;
    int   cyc     = 0;
    int   rsp_cnt = 0;
    int   rsp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_tot++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
                check("rsp_result", rsp_result, e.res);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            rsp_cnt++;
            rsp_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        if (!got) fail_now("gnt_wait");
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_cnt < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (rsp_cnt < n) fail_now("rsp_wait");
    endtask

    task automatic push(input int p, input logic [31:0] r, input logic err);
        exp_t e;
        e.owner = p;
        e.res   = r;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic err, input int lat);
        bit got;
        int tg;
        int n0;
        tick();
        a_in[32*p +: 32] = a;
        b_in[32*p +: 32] = b;
        req[p] = 1'b1;
        wait_gnt(got);
        check("gnt_onehot", 32'(gnt), 32'(1) << p);
        tg = cyc;
        n0 = rsp_cnt;
        if (got) push(p, r, err);
        tick();
        req[p] = 1'b0;
        @(negedge clk);
        check("start_t1", 32'(fp_start), 32'd1);
        check("fp_a", fp_a, a);
        check("fp_b", fp_b, b);
        check("busy_op", 32'(busy), 32'd1);
        wait_rsp(n0 + 1);
        check("latency", 32'(rsp_cyc - tg), 32'(lat));
    endtask

    logic [31:0] rr_a [4] = '{ONE, TWO, THREE, FOUR};
    logic [31:0] rr_p [4] = '{32'h4000_0000, 32'h4080_0000,
                              32'h40C0_0000, 32'h4100_0000};

    initial begin
        bit got;
        int n0;
        int tlast;
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_ctrl", 32'({gnt, rsp_valid, rsp_err, fp_start, busy}), 32'd0);
        check("rst_fp_a", fp_a, 32'd0);
        check("rst_fp_b", fp_b, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({gnt, busy, fp_start}), 32'd0);
        end

        run_op(1, TWO, THREE, 32'h40C0_0000, 1'b0, 6);
        run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 6);
        run_op(2, 32'hC000_0000, THREE, 32'hC0C0_0000, 1'b0, 6);

        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[32*i +: 32] = rr_a[i];
            b_in[32*i +: 32] = TWO;
        end
        n0    = rsp_cnt;
        tlast = 0;
        req   = '1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(got);
            check("rr_gnt", 32'(gnt), 32'(1) << (g % 4));
            check("rr_busy", 32'(busy), 32'd0);
            if (g > 0) check("rr_interval", 32'(cyc - tlast), 32'd7);
            tlast = cyc;
            if (got) push(g % 4, rr_p[g % 4], 1'b0);
            if (g == 4) begin
                tick();
                req = '0;
            end
        end
        wait_rsp(n0 + 5);

        tick();
        a_in[32 +: 32] = ONE;
        b_in[32 +: 32] = ONE;
        req[1] = 1'b1;
        wait_gnt(got);
        check("mid_gnt", 32'(gnt), 32'd2);
        tick();
        req[1] = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_idle", 32'({busy, rsp_valid}), 32'd0);
        check("mid_rst_fp_a", fp_a, 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        check("mid_no_rsp", 32'(rsp_cnt - n0), 32'd5);
        run_op(3, THREE, THREE, 32'h4110_0000, 1'b0, 6);

`ifdef FP_ARB_TIMEOUT_EN
        hang = 1'b1;
        run_op(2, TWO, THREE, 32'h7FC0_0000, 1'b1, 18);
        hang = 1'b0;
        repeat (6) tick();
        check("to_idle", 32'(busy), 32'd0);
`endif

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: run did not finish");
        $fatal(1, "global timeout");
    end

endmodule
